// File: rtl/dmem_pkg.sv
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared definitions for the byte-lane data memory: access-size
//             encodings, clear-engine state encoding and the byte-enable
//             helper used by the store path.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    // Access size encodings carried on req_size (2'b11 is illegal)
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Clear-engine state encoding
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // Byte-enable for a store of the given size at the given byte lane.
    // Misalignment is judged elsewhere; this only maps size/lane to lanes.
    function automatic logic [3:0] be_of(input logic [1:0] size,
                                         input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << lane;
            SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
//  Module   : dmem_lane_align
//  Purpose  : Combinational byte-lane steering for the data memory.
//             Store side: replicates store data across lanes, produces the
//             byte enable and flags misaligned / illegal-size accesses.
//             Load side: extracts the addressed byte/half and sign- or
//             zero-extends it.
//  Ports    : st_size/st_lane/st_wdata -> st_wdata_al, st_be, st_err
//             ld_word/ld_lane/ld_size/ld_uns -> ld_data
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_wdata_al,
    output logic [3:0]  st_be,
    output logic        st_err,

    input  logic [31:0] ld_word,
    input  logic [1:0]  ld_lane,
    input  logic [1:0]  ld_size,
    input  logic        ld_uns,
    output logic [31:0] ld_data
);

    logic [31:0] w_shift;

    // ---------------- store side ----------------
    always_comb begin
        case (st_size)
            SZ_B:    st_err = 1'b0;
            SZ_H:    st_err = st_lane[0];
            SZ_W:    st_err = (st_lane != 2'b00);
            default: st_err = 1'b1;
        endcase
    end

    // Data is replicated so each enabled lane already holds the right byte
    always_comb begin
        case (st_size)
            SZ_B:    st_wdata_al = {4{st_wdata[7:0]}};
            SZ_H:    st_wdata_al = {2{st_wdata[15:0]}};
            default: st_wdata_al = st_wdata;
        endcase
    end

    assign st_be = st_err ? 4'b0000 : be_of(st_size, st_lane);

    // ---------------- load side ----------------
    // Shifting the addressed lane down to bit 0 serves byte and half alike;
    // for a legal word access the lane is zero so the shift is a no-op.
    assign w_shift = ld_word >> {ld_lane, 3'b000};

    always_comb begin
        case (ld_size)
            SZ_B:    ld_data = ld_uns ? {24'h0, w_shift[7:0]}
                                      : {{24{w_shift[7]}}, w_shift[7:0]};
            SZ_H:    ld_data = ld_uns ? {16'h0, w_shift[15:0]}
                                      : {{16{w_shift[15]}}, w_shift[15:0]};
            SZ_W:    ld_data = w_shift;
            default: ld_data = 32'h0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_bytelane.sv
// ============================================================================
//  Module   : dmem_bytelane
//  Purpose  : Word-organised data memory with byte-lane stores, extended
//             loads returned through an RD_LAT-stage valid pipeline, error
//             flagging of misaligned/illegal accesses and a one-shot clear
//             engine that zeroes the array.
//  Ports    : clk, rst (sync, active-high)
//             req_valid/req_ready/req_we/req_size/req_uns/req_addr/req_wdata
//             rsp_valid/rsp_rdata/rsp_err
//             clr_start/clr_busy
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter  int DEPTH   = 256,
    parameter  int RD_LAT  = 1,
    localparam int BADDR_W = $clog2(DEPTH*4)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_uns,
    input  logic [BADDR_W-1:0] req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    input  logic               clr_start,
    output logic               clr_busy
);

    localparam int                 c_IDX_W = $clog2(DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(DEPTH - 1);

    logic [31:0]        r_mem [DEPTH];

    state_t             r_state, w_state_nxt;
    logic [c_IDX_W-1:0] r_ptr,   w_ptr_nxt;

    logic               w_accept;
    logic [c_IDX_W-1:0] w_idx;
    logic [1:0]         w_lane;
    logic [31:0]        w_wdata_al;
    logic [3:0]         w_be;
    logic               w_err;

    // Stage 1: registered RAM read plus the request attributes needed later
    logic               r_s1_valid;
    logic               r_s1_load;
    logic               r_s1_err;
    logic [31:0]        r_s1_word;
    logic [1:0]         r_s1_lane;
    logic [1:0]         r_s1_size;
    logic               r_s1_uns;
    logic [31:0]        w_ld_data;
    logic [31:0]        w_s1_rdata;

    assign req_ready = (r_state == S_IDLE) && !clr_start;
    assign clr_busy  = (r_state == S_CLEAR);
    assign w_accept  = req_valid && req_ready;
    assign w_idx     = req_addr[BADDR_W-1:2];
    assign w_lane    = req_addr[1:0];

    dmem_lane_align u_align (
        .st_size     (req_size),
        .st_lane     (w_lane),
        .st_wdata    (req_wdata),
        .st_wdata_al (w_wdata_al),
        .st_be       (w_be),
        .st_err      (w_err),
        .ld_word     (r_s1_word),
        .ld_lane     (r_s1_lane),
        .ld_size     (r_s1_size),
        .ld_uns      (r_s1_uns),
        .ld_data     (w_ld_data)
    );

    // ---------------- RAM ----------------
    // Not reset: contents survive rst. The clear engine and the request
    // port never write in the same cycle because requests are only
    // accepted in IDLE. w_be is zero for erroneous accesses.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_ptr] <= '0;
        end else if (w_accept && req_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_al[8*b +: 8];
                end
            end
        end
    end

    // ---------------- response stage 1 ----------------
    // The read sees the word as it was before any store in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_load  <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_word  <= '0;
            r_s1_lane  <= '0;
            r_s1_size  <= '0;
            r_s1_uns   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_word <= r_mem[w_idx];
                r_s1_lane <= w_lane;
                r_s1_size <= req_size;
                r_s1_uns  <= req_uns;
                r_s1_err  <= w_err;
                r_s1_load <= !req_we && !w_err;
            end
        end
    end

    // Stores and errors return zero data
    assign w_s1_rdata = (r_s1_valid && r_s1_load) ? w_ld_data : 32'h0;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic        r_s2_valid;
            logic        r_s2_err;
            logic [31:0] r_s2_rdata;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s2_valid <= 1'b0;
                    r_s2_err   <= 1'b0;
                    r_s2_rdata <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    r_s2_err   <= r_s1_valid && r_s1_err;
                    r_s2_rdata <= w_s1_rdata;
                end
            end

            assign rsp_valid = r_s2_valid;
            assign rsp_err   = r_s2_err;
            assign rsp_rdata = r_s2_rdata;
        end else begin : g_lat1
            assign rsp_valid = r_s1_valid;
            assign rsp_err   = r_s1_valid && r_s1_err;
            assign rsp_rdata = w_s1_rdata;
        end
    endgenerate

    // ---------------- clear engine ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (clr_start) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_ptr_nxt = r_ptr + c_IDX_W'(1);
                if (r_ptr == c_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire
